// File: rtl/game_pkg.sv
// Shared types and constants for the number-hit game logic.
// Holds the controller FSM encoding, score limit and LFSR feedback mask.
package game_pkg;

    localparam int NUMBERS_DEFAULT = 18;

    localparam logic [7:0] BCD_MAX = 8'h99;

    // Feedback mask for x^16+x^14+x^13+x^11+1 in a left-shifting register (bits 15,13,12,10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        RESOLVE = 2'd1,
        REFRESH = 2'd2
    } state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that shifts left every cycle.
// The seed is loaded on reset and must be non-zero.
module lfsr16
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= seed;
        end else begin
            value <= {value[14:0], ^(value & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/number_hit_controller.sv
// Turns player/number sprite overlaps into one scored hit per frame.
// It then re-rolls the digit shown on the number that was hit.
module number_hit_controller
    import game_pkg::*;
#(
    parameter int          NUMBERS   = NUMBERS_DEFAULT,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    playerDR,
    input  logic [NUMBERS-1:0]      numbersDR,
    input  logic [NUMBERS-1:0]      showNum,
    input  logic [3:0]              targetDigit,
    output logic [NUMBERS-1:0]      singleHit,
    output logic [NUMBERS-1:0][3:0] numbersToShow,
    output logic [7:0]              scoreBCD,
    output logic                    correctHit,
    output logic                    wrongHit
);

    localparam int IDX_W = (NUMBERS > 1) ? $clog2(NUMBERS) : 1;

    state_t               state;
    state_t               next_state;
    logic [NUMBERS-1:0]   pending;
    logic [NUMBERS-1:0]   collisions;
    logic [NUMBERS-1:0]   pending_all;
    logic [IDX_W-1:0]     sel_index;
    logic [IDX_W-1:0]     hit_index;
    logic                 is_match;
    logic [15:0]          lfsr_value;
    logic [3:0]           lfsr_digit;
    logic                 lfsr_unused;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == BCD_MAX) begin
            return v;
        end
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00) begin
            return v;
        end
        if (v[3:0] == 4'd0) begin
            return {v[7:4] - 4'd1, 4'd9};
        end
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .value (lfsr_value)
    );

    assign lfsr_digit  = lfsr_value[3:0];
    assign lfsr_unused = ^lfsr_value[15:4];

    // Hidden numbers never collide; a collision on the SOF cycle itself still counts.
    assign collisions  = {NUMBERS{playerDR}} & numbersDR & showNum;
    assign pending_all = pending | collisions;

    // Lowest pending index wins; higher indices in the same frame are dropped.
    always_comb begin
        sel_index = '0;
        for (int i = NUMBERS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_index = IDX_W'(i);
            end
        end
    end

    assign is_match = (numbersToShow[sel_index] == targetDigit);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SCAN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            SCAN: begin
                if (startOfFrame && (|pending_all)) begin
                    next_state = RESOLVE;
                end
            end
            RESOLVE: next_state = REFRESH;
            REFRESH: begin
                if (lfsr_digit <= 4'd9) begin
                    next_state = SCAN;
                end
            end
            default: next_state = SCAN;
        endcase
    end

    always_comb begin
        singleHit  = '0;
        correctHit = 1'b0;
        wrongHit   = 1'b0;
        if (state == RESOLVE) begin
            singleHit[sel_index] = 1'b1;
            correctHit           = is_match;
            wrongHit             = !is_match;
        end
    end

    // RESOLVE wipes the resolved frame but keeps collisions arriving in that same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            hit_index <= '0;
            scoreBCD  <= 8'h00;
            for (int i = 0; i < NUMBERS; i++) begin
                numbersToShow[i] <= 4'(i % 10);
            end
        end else begin
            case (state)
                RESOLVE: begin
                    pending   <= collisions;
                    hit_index <= sel_index;
                    scoreBCD  <= is_match ? bcd_inc(scoreBCD) : bcd_dec(scoreBCD);
                end
                REFRESH: begin
                    pending <= pending_all;
                    if (lfsr_digit <= 4'd9) begin
                        numbersToShow[hit_index] <= lfsr_digit;
                    end
                end
                default: pending <= pending_all;
            endcase
        end
    end

endmodule

// File: tb/tb_number_hit_controller.sv
// Directed bench for number_hit_controller: a vector table plus hand-written sequences.
// The sequences cover REFRESH dwell, score saturation, BCD borrow and mid-REFRESH reset.
module tb_number_hit_controller;

    localparam int          N    = 18;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          NV   = 15;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                startOfFrame = 1'b0;
    logic                playerDR = 1'b0;
    logic [N-1:0]        numbersDR = '0;
    logic [N-1:0]        showNum = '1;
    logic [3:0]          targetDigit = 4'd0;
    logic [N-1:0]        singleHit;
    logic [N-1:0][3:0]   numbersToShow;
    logic [7:0]          scoreBCD;
    logic                correctHit;
    logic                wrongHit;

    int          errors = 0;
    int          checks = 0;
    int          score_int = 0;
    logic [15:0] model_lfsr;
    logic [3:0]  digit_model [N];

    typedef struct {
        logic         sof;
        logic         player;
        logic [N-1:0] dr;
        logic [N-1:0] show;
        logic [3:0]   target;
        logic [N-1:0] exp_hit;
        logic         exp_correct;
        logic         exp_wrong;
        logic [7:0]   exp_score;
        int           refresh_idx;
        string        name;
    } vec_t;

    vec_t vectors [NV];

    number_hit_controller #(
        .NUMBERS   (N),
        .LFSR_SEED (SEED)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (startOfFrame),
        .playerDR      (playerDR),
        .numbersDR     (numbersDR),
        .showNum       (showNum),
        .targetDigit   (targetDigit),
        .singleHit     (singleHit),
        .numbersToShow (numbersToShow),
        .scoreBCD      (scoreBCD),
        .correctHit    (correctHit),
        .wrongHit      (wrongHit)
    );

    always #5 clk = ~clk;

    // Reference LFSR for x^16+x^14+x^13+x^11+1, used to predict the refreshed digit.
    always @(posedge clk) begin
        if (reset) begin
            model_lfsr <= SEED;
        end else begin
            model_lfsr <= {model_lfsr[14:0],
                           model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
        end
    end

    function automatic logic [7:0] bcd_of(input int s);
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [N-1:0] bit_of(input int k);
        logic [N-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic sof, input logic player, input logic [N-1:0] dr,
                                  input logic [N-1:0] show, input logic [3:0] target);
        @(negedge clk);
        startOfFrame = sof;
        playerDR     = player;
        numbersDR    = dr;
        showNum      = show;
        targetDigit  = target;
        @(posedge clk);
        #1;
    endtask

    task automatic check_pulses_idle(input string name);
        check_output({name, "_hit"}, 32'(singleHit), 32'd0);
        check_output({name, "_correct"}, 32'(correctHit), 32'd0);
        check_output({name, "_wrong"}, 32'(wrongHit), 32'd0);
    endtask

    task automatic check_reset_state(input string name);
        check_pulses_idle(name);
        check_output({name, "_score"}, 32'(scoreBCD), 32'h00);
        for (int i = 0; i < N; i++) begin
            check_output($sformatf("%s_digit%0d", name, i), 32'(numbersToShow[i]), 32'(i % 10));
        end
    endtask

    // Called in the first REFRESH cycle; idles until the reload and checks the new digit.
    task automatic wait_refresh(input int k);
        logic [3:0] nib;
        bit         done;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            nib          = model_lfsr[3:0];
            startOfFrame = 1'b0;
            playerDR     = 1'b0;
            numbersDR    = '0;
            @(posedge clk);
            #1;
            if (nib <= 4'd9) begin
                done = 1'b1;
                digit_model[k] = nib;
                check_output($sformatf("refresh_digit%0d", k), 32'(numbersToShow[k]), 32'(nib));
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL refresh_timeout%0d: actual=no reload expected=reload within 64 cycles", k);
        end
    endtask

    task automatic do_hit(input int k, input bit correct);
        logic [3:0] t;
        t = correct ? digit_model[k] : 4'((digit_model[k] + 1) % 10);
        apply_stimulus(1'b0, 1'b1, bit_of(k), '1, t);
        apply_stimulus(1'b1, 1'b0, '0, '1, t);
        check_output($sformatf("hit%0d_single", k), 32'(singleHit), 32'(bit_of(k)));
        check_output($sformatf("hit%0d_correct", k), 32'(correctHit), 32'(correct));
        check_output($sformatf("hit%0d_wrong", k), 32'(wrongHit), 32'(!correct));
        apply_stimulus(1'b0, 1'b0, '0, '1, t);
        if (correct) begin
            score_int = (score_int < 99) ? score_int + 1 : 99;
        end else begin
            score_int = (score_int > 0) ? score_int - 1 : 0;
        end
        check_output($sformatf("hit%0d_score", k), 32'(scoreBCD), 32'(bcd_of(score_int)));
        wait_refresh(k);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual=still running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] nib;
        logic [3:0] t;

        for (int i = 0; i < N; i++) begin
            digit_model[i] = 4'(i % 10);
        end

        //          sof  ply  dr        show              tgt  exp_hit   c     w     score  rfr name
        vectors[0]  = '{1'b0, 1'b0, 18'h0,   18'h3FFFF,       4'd9, 18'h0,   1'b0, 1'b0, 8'h00, -1, "idle"};
        vectors[1]  = '{1'b0, 1'b1, 18'h8,   18'h3FFF7,       4'd9, 18'h0,   1'b0, 1'b0, 8'h00, -1, "hidden3"};
        vectors[2]  = '{1'b1, 1'b0, 18'h0,   18'h3FFFF,       4'd9, 18'h0,   1'b0, 1'b0, 8'h00, -1, "sof_hidden"};
        vectors[3]  = '{1'b0, 1'b0, 18'h0,   18'h3FFFF,       4'd9, 18'h0,   1'b0, 1'b0, 8'h00, -1, "after_hidden"};
        vectors[4]  = '{1'b0, 1'b1, 18'h84,  18'h3FFFF,       4'd9, 18'h0,   1'b0, 1'b0, 8'h00, -1, "col2_7"};
        vectors[5]  = '{1'b1, 1'b0, 18'h0,   18'h3FFFF,       4'd9, 18'h4,   1'b0, 1'b1, 8'h00, -1, "sof_2_7"};
        vectors[6]  = '{1'b0, 1'b0, 18'h0,   18'h3FFFF,       4'd9, 18'h0,   1'b0, 1'b0, 8'h00,  2, "floor00"};
        vectors[7]  = '{1'b0, 1'b0, 18'h0,   18'h3FFFF,       4'd9, 18'h0,   1'b0, 1'b0, 8'h00, -1, "idle2"};
        vectors[8]  = '{1'b1, 1'b0, 18'h0,   18'h3FFFF,       4'd9, 18'h0,   1'b0, 1'b0, 8'h00, -1, "no_hit7"};
        vectors[9]  = '{1'b0, 1'b0, 18'h0,   18'h3FFFF,       4'd4, 18'h0,   1'b0, 1'b0, 8'h00, -1, "idle3"};
        vectors[10] = '{1'b0, 1'b1, 18'h10,  18'h3FFFF,       4'd4, 18'h0,   1'b0, 1'b0, 8'h00, -1, "col4"};
        vectors[11] = '{1'b1, 1'b0, 18'h0,   18'h3FFFF,       4'd4, 18'h10,  1'b1, 1'b0, 8'h00, -1, "sof_4"};
        vectors[12] = '{1'b0, 1'b0, 18'h0,   18'h3FFFF,       4'd4, 18'h0,   1'b0, 1'b0, 8'h01,  4, "score01"};
        vectors[13] = '{1'b1, 1'b1, 18'h200, 18'h3FFFF,       4'd9, 18'h200, 1'b1, 1'b0, 8'h01, -1, "sof_col9"};
        vectors[14] = '{1'b0, 1'b0, 18'h0,   18'h3FFFF,       4'd9, 18'h0,   1'b0, 1'b0, 8'h02,  9, "score02"};

        $display("[TB] reset check");
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("in_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(1'b0, 1'b0, '0, '1, 4'd0);
            check_pulses_idle($sformatf("post_reset%0d", c));
        end
        check_reset_state("released");

        $display("[TB] vector table");
        for (int r = 0; r < NV; r++) begin
            apply_stimulus(vectors[r].sof, vectors[r].player, vectors[r].dr,
                           vectors[r].show, vectors[r].target);
            check_output({vectors[r].name, "_hit"}, 32'(singleHit), 32'(vectors[r].exp_hit));
            check_output({vectors[r].name, "_correct"}, 32'(correctHit), 32'(vectors[r].exp_correct));
            check_output({vectors[r].name, "_wrong"}, 32'(wrongHit), 32'(vectors[r].exp_wrong));
            check_output({vectors[r].name, "_score"}, 32'(scoreBCD), 32'(vectors[r].exp_score));
            if (vectors[r].refresh_idx >= 0) begin
                wait_refresh(vectors[r].refresh_idx);
            end
        end
        score_int = 2;

        $display("[TB] startOfFrame during REFRESH is ignored");
        t = digit_model[0];
        apply_stimulus(1'b0, 1'b1, bit_of(0), '1, t);
        apply_stimulus(1'b1, 1'b0, '0, '1, t);
        check_output("ign_hit0", 32'(singleHit), 32'(bit_of(0)));
        apply_stimulus(1'b0, 1'b0, '0, '1, t);
        score_int++;
        check_output("ign_score", 32'(scoreBCD), 32'(bcd_of(score_int)));
        @(negedge clk);
        nib          = model_lfsr[3:0];
        startOfFrame = 1'b1;
        playerDR     = 1'b1;
        numbersDR    = bit_of(1);
        @(posedge clk);
        #1;
        check_pulses_idle("sof_in_refresh");
        if (nib <= 4'd9) begin
            digit_model[0] = nib;
            check_output("refresh_digit0", 32'(numbersToShow[0]), 32'(nib));
        end else begin
            wait_refresh(0);
        end
        t = digit_model[1];
        apply_stimulus(1'b1, 1'b0, '0, '1, t);
        check_output("late_hit1", 32'(singleHit), 32'(bit_of(1)));
        check_output("late_correct1", 32'(correctHit), 32'd1);
        apply_stimulus(1'b0, 1'b0, '0, '1, t);
        score_int++;
        check_output("late_score", 32'(scoreBCD), 32'(bcd_of(score_int)));
        wait_refresh(1);

        $display("[TB] climb to 98 then saturate at 99");
        for (int i = 0; score_int < 98 && i < 200; i++) begin
            do_hit(i % N, 1'b1);
        end
        check_output("at98", 32'(scoreBCD), 32'h98);
        do_hit(3, 1'b1);
        check_output("sat99_a", 32'(scoreBCD), 32'h99);
        do_hit(11, 1'b1);
        check_output("sat99_b", 32'(scoreBCD), 32'h99);

        $display("[TB] descend to 10 then borrow to 09");
        for (int i = 0; score_int > 10 && i < 200; i++) begin
            do_hit((i * 5) % N, 1'b0);
        end
        check_output("at10", 32'(scoreBCD), 32'h10);
        do_hit(6, 1'b0);
        check_output("borrow09", 32'(scoreBCD), 32'h09);

        $display("[TB] reset during REFRESH");
        t = digit_model[5];
        apply_stimulus(1'b0, 1'b1, bit_of(5), '1, t);
        apply_stimulus(1'b1, 1'b0, '0, '1, t);
        check_output("mid_hit5", 32'(singleHit), 32'(bit_of(5)));
        apply_stimulus(1'b0, 1'b1, bit_of(6), '1, t);
        @(negedge clk);
        reset     = 1'b1;
        playerDR  = 1'b0;
        numbersDR = '0;
        @(posedge clk);
        #1;
        check_reset_state("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        score_int = 0;
        for (int i = 0; i < N; i++) begin
            digit_model[i] = 4'(i % 10);
        end
        for (int c = 0; c < 6; c++) begin
            apply_stimulus(c[0], 1'b0, '0, '1, 4'd6);
            check_pulses_idle($sformatf("stale%0d", c));
        end
        check_output("stale_score", 32'(scoreBCD), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
